pid_trigger_gate: RTL and testbench
===================================

Name: pid_trigger_gate

Overview:
- Consumes the per-channel Electron/Pion/Muon match pulses from the NCH fine-time channels on the 50 MHz clock. Forms one PID trigger per event, with per-species enable, prescale, fixed deadtime and a busy flag.
- Keeps raw and accepted scalers, all accessible on the local bus. It is the stage directly downstream of the per-channel fine-time/PID decoders and sits before the trigger output/fan-out logic.

Parameters:
- NCH, 8, number of channels OR-ed per species
- BASE, 8'h80, local-bus base address; registers at BASE+0..BASE+6
- DEAD_DEF, 16'd10, reset value of DEADTIME register (clk cycles)

Ports:
- clk  in  1  50 MHz system clock, the same clock as the upstream PID comparators
- rst  in  1  synchronous, active-high reset
- Electron  in  NCH  per-channel electron match, one bit per channel, clk-synchronous level
- Pion  in  NCH  per-channel pion match
- Muon  in  NCH  per-channel muon match
- DataIn  in  32  local-bus write data
- Address  in  8  local-bus address
- Read  in  1  local-bus read strobe
- Write  in  1  local-bus write strobe
- DataOut  out  32  read data; 0 when the address is not selected or Read is low (OR-combined on the bus)
- Trigger  out  1  one-cycle accepted-trigger pulse
- TrigType  out  2  species of the last accepted trigger: 01 = E, 10 = P, 11 = M, 00 = none since reset
- Busy  out  1  high during FIRE and DEAD states

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset values: Trigger=0, TrigType=00, Busy=0, state=IDLE, all counters/scalers=0, CTRL=32'h7, PRESCALE=0, DEADTIME=DEAD_DEF.
- Stage 1 input register: hE/hP/hM = registered OR-reduction of Electron/Pion/Muon. Each high cycle counts as one hit.
- Register map:
  - BASE+0 CTRL: [0] enE, [1] enP, [2] enM, [3] scaler clear (self-clearing, always reads 0).
  - BASE+1 PRESCALE: [7:0] E, [15:8] P, [23:16] M. Value N accepts 1 of every N+1 hits.
  - BASE+2 DEADTIME: [15:0], all other bits read 0.
  - BASE+3/4/5: raw scalers E/P/M, read-only.
  - BASE+6: accepted-trigger scaler, read-only.
- Bus timing: a write is captured at the clk edge where Write=1 and the address matches. Reads are combinational. Writes to read-only addresses are ignored.
- Raw scalers: each increments on every cycle its hX=1, in any state. They saturate at 32'hFFFF_FFFF.
- Scaler clear: clears all 4 scalers on the next edge. It wins over a simultaneous increment.
- Prescale counter pc, per species, 8-bit. It updates only in IDLE and only when hX & enX:
  - if pc==0, the species is a candidate and pc is reloaded to N;
  - otherwise pc decrements.
  - Any write to PRESCALE zeroes all three pc.
- FSM IDLE:
  - If any candidate exists, go to FIRE and latch TrigType. Priority is M > P > E.
  - Non-winning simultaneous candidates are dropped, but their pc still reloads.
- FSM FIRE (1 cycle): Trigger=1, Busy=1, accepted scaler +1 (saturating).
  - If DEADTIME==0, next state is IDLE.
  - Otherwise, load dc=DEADTIME and go to DEAD.
- FSM DEAD: Busy=1, dc decrements; when dc==1, next state is IDLE. Hits arriving during FIRE/DEAD do not touch pc.
- Latency and pacing: a hit on an input at the cycle-n edge gives Trigger high in cycle n+2. Busy lasts exactly 1+DEADTIME cycles. The minimum trigger spacing is 2+DEADTIME cycles.
- Register changes mid-operation:
  - A DEADTIME write during DEAD does not affect the running dc.
  - Clearing enX takes effect on the next IDLE evaluation.
- rst asserted in any state returns every output and register to its reset value at that edge. No Trigger pulse is emitted on that edge.

Decomposition:
- Package pid_trig_pkg:
  - state enum {IDLE, FIRE, DEAD};
  - TrigType codes TT_NONE/TT_E/TT_P/TT_M;
  - register offsets OFS_CTRL..OFS_ACC;
  - CTRL bit indices.
- Sub-module pid_prescaler, instantiated 3 times:
  - inputs: hit, en, idle, N, zero (PRESCALE write);
  - outputs: cand.
  - It holds the 8-bit pc.

Test Plan:
- Reset, then read BASE+0/+1/+2 -> 32'h7, 0, DEAD_DEF (10). Trigger=0, Busy=0.
- Single cycle Muon[3]=1 at cycle n:
  - Trigger=1 only in cycle n+2, TrigType=11;
  - Busy high for 11 cycles;
  - BASE+5 reads 1 and BASE+6 reads 1.
- Electron[0] and Pion[5] high in the same cycle -> one Trigger with TrigType=10; BASE+3 and BASE+4 both read 1.
- PRESCALE E=3, 8 Electron hits spaced 20 cycles apart -> Triggers on hits 1 and 5 only; raw E scaler reads 8 and accepted scaler reads 2.
- DEADTIME=0, Pion held high for 10 cycles -> Trigger every 2nd cycle, 5 pulses; accepted scaler reads 5 and raw P scaler reads 10.
- Write CTRL=32'h8 while hits arrive -> all scalers read 0 next cycle, CTRL reads 0, and no Trigger is produced with all species disabled.
- Assert rst for 1 cycle during DEAD -> Busy=0 on the next cycle; a hit 3 cycles later triggers normally.

Source files
------------

// File: rtl/pid_trig_pkg.sv
// Shared types and constants for the PID trigger gate: FSM states,
// trigger-type codes, local-bus register offsets and CTRL bit positions.
package pid_trig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [1:0] TT_NONE = 2'b00;
    localparam logic [1:0] TT_E    = 2'b01;
    localparam logic [1:0] TT_P    = 2'b10;
    localparam logic [1:0] TT_M    = 2'b11;

    localparam logic [7:0] OFS_CTRL     = 8'd0;
    localparam logic [7:0] OFS_PRESCALE = 8'd1;
    localparam logic [7:0] OFS_DEADTIME = 8'd2;
    localparam logic [7:0] OFS_RAW_E    = 8'd3;
    localparam logic [7:0] OFS_RAW_P    = 8'd4;
    localparam logic [7:0] OFS_RAW_M    = 8'd5;
    localparam logic [7:0] OFS_ACC      = 8'd6;

    localparam int CTRL_EN_E = 0;
    localparam int CTRL_EN_P = 1;
    localparam int CTRL_EN_M = 2;
    localparam int CTRL_CLR  = 3;

    // Scalers stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pid_prescaler.sv
// Per-species prescaler: flags a trigger candidate on one of every N+1
// enabled hits seen while the gate is idle.
module pid_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       en,
    input  logic       idle,
    input  logic [7:0] n,
    input  logic       zero,
    output logic       cand
);

    logic [7:0] pc;
    logic       take;

    assign take = idle & hit & en;
    assign cand = take & (pc == 8'd0);

    // Countdown reloads to N on an accepted hit; a PRESCALE write restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 8'd0;
        end else if (zero) begin
            pc <= 8'd0;
        end else if (take) begin
            pc <= (pc == 8'd0) ? n : pc - 8'd1;
        end
    end

endmodule

// File: rtl/pid_trigger_gate.sv
// PID trigger gate: ORs per-channel E/P/M matches, applies enable and
// prescale, fires one trigger per event followed by a fixed deadtime,
// and exposes control registers and scalers on the local bus.
module pid_trigger_gate #(
    parameter int          NCH      = 8,
    parameter logic [7:0]  BASE     = 8'h80,
    parameter logic [15:0] DEAD_DEF = 16'd10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] Electron,
    input  logic [NCH-1:0] Pion,
    input  logic [NCH-1:0] Muon,
    input  logic [31:0]    DataIn,
    input  logic [7:0]     Address,
    input  logic           Read,
    input  logic           Write,
    output logic [31:0]    DataOut,
    output logic           Trigger,
    output logic [1:0]     TrigType,
    output logic           Busy
);
    import pid_trig_pkg::*;

    logic        hit_e, hit_p, hit_m;
    logic [7:0]  ofs;
    logic        wr_ctrl, wr_pre, wr_dead, scaler_clr;
    logic [2:0]  ctrl_en;
    logic [23:0] prescale;
    logic [15:0] deadtime;
    logic [31:0] raw_e, raw_p, raw_m, acc;
    logic        cand_e, cand_p, cand_m, idle;
    state_t      state, state_nx;
    logic [15:0] dc, dc_nx;
    logic [1:0]  tt_nx;
    logic        unused_bits;

    assign ofs        = Address - BASE;
    assign wr_ctrl    = Write && (ofs == OFS_CTRL);
    assign wr_pre     = Write && (ofs == OFS_PRESCALE);
    assign wr_dead    = Write && (ofs == OFS_DEADTIME);
    assign scaler_clr = wr_ctrl && DataIn[CTRL_CLR];
    assign unused_bits = ^DataIn[31:24];

    assign idle    = (state == IDLE);
    assign Trigger = (state == FIRE);
    assign Busy    = (state != IDLE);

    // Stage-1 register: one hit per species per cycle, any channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_e <= 1'b0;
            hit_p <= 1'b0;
            hit_m <= 1'b0;
        end else begin
            hit_e <= |Electron;
            hit_p <= |Pion;
            hit_m <= |Muon;
        end
    end

    // Writable control registers; the clear bit is a strobe and is not stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en  <= 3'b111;
            prescale <= 24'd0;
            deadtime <= DEAD_DEF;
        end else begin
            if (wr_ctrl) ctrl_en  <= DataIn[2:0];
            if (wr_pre)  prescale <= DataIn[23:0];
            if (wr_dead) deadtime <= DataIn[15:0];
        end
    end

    // Raw and accepted scalers; a clear strobe beats a same-edge increment.
    always_ff @(posedge clk) begin
        if (rst || scaler_clr) begin
            raw_e <= 32'd0;
            raw_p <= 32'd0;
            raw_m <= 32'd0;
            acc   <= 32'd0;
        end else begin
            if (hit_e)           raw_e <= sat_inc(raw_e);
            if (hit_p)           raw_p <= sat_inc(raw_p);
            if (hit_m)           raw_m <= sat_inc(raw_m);
            if (state == FIRE)   acc   <= sat_inc(acc);
        end
    end

    pid_prescaler u_pre_e (
        .clk(clk), .rst(rst), .hit(hit_e), .en(ctrl_en[CTRL_EN_E]), .idle(idle),
        .n(prescale[7:0]), .zero(wr_pre), .cand(cand_e)
    );

    pid_prescaler u_pre_p (
        .clk(clk), .rst(rst), .hit(hit_p), .en(ctrl_en[CTRL_EN_P]), .idle(idle),
        .n(prescale[15:8]), .zero(wr_pre), .cand(cand_p)
    );

    pid_prescaler u_pre_m (
        .clk(clk), .rst(rst), .hit(hit_m), .en(ctrl_en[CTRL_EN_M]), .idle(idle),
        .n(prescale[23:16]), .zero(wr_pre), .cand(cand_m)
    );

    // FSM state, deadtime counter and last-accepted species.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dc       <= 16'd0;
            TrigType <= TT_NONE;
        end else begin
            state    <= state_nx;
            dc       <= dc_nx;
            TrigType <= tt_nx;
        end
    end

    // Next-state logic: M beats P beats E; deadtime is sampled once in FIRE.
    always_comb begin
        state_nx = state;
        dc_nx    = dc;
        tt_nx    = TrigType;
        case (state)
            IDLE: begin
                if (cand_m) begin
                    state_nx = FIRE;
                    tt_nx    = TT_M;
                end else if (cand_p) begin
                    state_nx = FIRE;
                    tt_nx    = TT_P;
                end else if (cand_e) begin
                    state_nx = FIRE;
                    tt_nx    = TT_E;
                end
            end
            FIRE: begin
                if (deadtime == 16'd0) begin
                    state_nx = IDLE;
                end else begin
                    dc_nx    = deadtime;
                    state_nx = DEAD;
                end
            end
            DEAD: begin
                dc_nx = dc - 16'd1;
                if (dc <= 16'd1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Combinational read mux; idle bus returns zero so outputs can be OR-ed.
    always_comb begin
        DataOut = 32'd0;
        if (Read) begin
            case (ofs)
                OFS_CTRL:     DataOut = {29'd0, ctrl_en};
                OFS_PRESCALE: DataOut = {8'd0, prescale};
                OFS_DEADTIME: DataOut = {16'd0, deadtime};
                OFS_RAW_E:    DataOut = raw_e;
                OFS_RAW_P:    DataOut = raw_p;
                OFS_RAW_M:    DataOut = raw_m;
                OFS_ACC:      DataOut = acc;
                default:      DataOut = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_trigger_gate.sv
// Directed testbench for pid_trigger_gate: expected triggers are queued
// when hits are driven and checked by a monitor when Trigger pulses.
module tb_pid_trigger_gate;
    import pid_trig_pkg::*;

    localparam int          NCH      = 8;
    localparam logic [7:0]  BASE     = 8'h80;
    localparam logic [15:0] DEAD_DEF = 16'd10;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] Electron, Pion, Muon;
    logic [31:0]    DataIn;
    logic [7:0]     Address;
    logic           Read, Write;
    logic [31:0]    DataOut;
    logic           Trigger;
    logic [1:0]     TrigType;
    logic           Busy;

    typedef struct {
        logic [1:0] tt;
        int         at;
    } exp_t;

    exp_t sbq[$];
    exp_t monE;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   busyCnt;
    int   c;

    pid_trigger_gate #(.NCH(NCH), .BASE(BASE), .DEAD_DEF(DEAD_DEF)) dut (
        .clk(clk), .rst(rst),
        .Electron(Electron), .Pion(Pion), .Muon(Muon),
        .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write),
        .DataOut(DataOut), .Trigger(Trigger), .TrigType(TrigType), .Busy(Busy)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Cycle index used to timestamp expected triggers
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expectTrig(input logic [1:0] tt, input int at);
        exp_t e;
        e.tt = tt;
        e.at = at;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] e, input logic [NCH-1:0] p,
                                 input logic [NCH-1:0] m, input int cycles);
        Electron = e;
        Pion     = p;
        Muon     = m;
        repeat (cycles) @(negedge clk);
        Electron = '0;
        Pion     = '0;
        Muon     = '0;
    endtask

    task automatic busWrite(input logic [7:0] ofs, input logic [31:0] data);
        Address = BASE + ofs;
        DataIn  = data;
        Write   = 1'b1;
        @(negedge clk);
        Write   = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [7:0] ofs, input logic [31:0] exp);
        Address = BASE + ofs;
        Read    = 1'b1;
        #1;
        checkOutput(tag, DataOut, exp);
        Read    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        Electron = '0; Pion = '0; Muon = '0;
        DataIn = '0; Address = '0; Read = 1'b0; Write = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (Trigger === 1'b1) begin
                    checkOutput("trigger_expected", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        monE = sbq.pop_front();
                        checkOutput("trig_cycle", cyc, monE.at);
                        checkOutput("trig_type", {30'd0, TrigType}, {30'd0, monE.tt});
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_trigger", {31'd0, Trigger}, 32'd0);
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_trigtype", {30'd0, TrigType}, 32'd0);
        Address = BASE;
        #1;
        checkOutput("read_low_zero", DataOut, 32'd0);
        readCheck("rst_ctrl", OFS_CTRL, 32'h7);
        readCheck("rst_prescale", OFS_PRESCALE, 32'h0);
        readCheck("rst_deadtime", OFS_DEADTIME, 32'd10);
        @(negedge clk);

        // Single muon hit
        $display("[TB] single muon hit");
        c = cyc;
        expectTrig(TT_M, c + 2);
        applyStimulus('0, '0, 8'h08, 1);
        busyCnt = 0;
        repeat (16) begin
            if (Busy) busyCnt++;
            @(negedge clk);
        end
        checkOutput("busy_len", busyCnt, 32'd11);
        checkOutput("muon_trigtype", {30'd0, TrigType}, {30'd0, TT_M});
        readCheck("muon_raw_m", OFS_RAW_M, 32'd1);
        readCheck("muon_acc", OFS_ACC, 32'd1);
        readCheck("muon_raw_e", OFS_RAW_E, 32'd0);

        // Electron and pion together: pion wins
        $display("[TB] simultaneous E and P");
        c = cyc;
        expectTrig(TT_P, c + 2);
        applyStimulus(8'h01, 8'h20, '0, 1);
        repeat (14) @(negedge clk);
        checkOutput("ep_trigtype", {30'd0, TrigType}, {30'd0, TT_P});
        readCheck("ep_raw_e", OFS_RAW_E, 32'd1);
        readCheck("ep_raw_p", OFS_RAW_P, 32'd1);
        readCheck("ep_acc", OFS_ACC, 32'd2);

        // Electron prescale of 3
        $display("[TB] electron prescale");
        busWrite(OFS_CTRL, 32'hF);
        busWrite(OFS_PRESCALE, 32'h3);
        readCheck("pre_readback", OFS_PRESCALE, 32'h3);
        for (int i = 0; i < 8; i++) begin
            c = cyc;
            if (i % 4 == 0) expectTrig(TT_E, c + 2);
            applyStimulus(8'h01, '0, '0, 1);
            repeat (19) @(negedge clk);
        end
        readCheck("pre_raw_e", OFS_RAW_E, 32'd8);
        readCheck("pre_acc", OFS_ACC, 32'd2);
        readCheck("pre_raw_p", OFS_RAW_P, 32'd0);

        // Zero deadtime, pion held for 10 cycles
        $display("[TB] zero deadtime");
        busWrite(OFS_PRESCALE, 32'h0);
        busWrite(OFS_DEADTIME, 32'h0);
        busWrite(OFS_CTRL, 32'hF);
        c = cyc;
        for (int k = 0; k < 5; k++) expectTrig(TT_P, c + 2 + 2 * k);
        applyStimulus('0, 8'h01, '0, 10);
        repeat (5) @(negedge clk);
        readCheck("dt0_acc", OFS_ACC, 32'd5);
        readCheck("dt0_raw_p", OFS_RAW_P, 32'd10);
        readCheck("dt0_deadtime", OFS_DEADTIME, 32'd0);

        // Scaler clear with all species disabled while hits arrive
        $display("[TB] scaler clear");
        Address  = BASE + OFS_CTRL;
        DataIn   = 32'h8;
        Write    = 1'b1;
        Electron = 8'h01;
        Muon     = 8'h80;
        @(negedge clk);
        Write = 1'b0;
        readCheck("clr_raw_e", OFS_RAW_E, 32'd0);
        readCheck("clr_raw_p", OFS_RAW_P, 32'd0);
        readCheck("clr_raw_m", OFS_RAW_M, 32'd0);
        readCheck("clr_acc", OFS_ACC, 32'd0);
        readCheck("clr_ctrl", OFS_CTRL, 32'd0);
        repeat (4) @(negedge clk);
        Electron = '0;
        Muon     = '0;
        repeat (10) @(negedge clk);
        readCheck("dis_raw_e", OFS_RAW_E, 32'd5);
        readCheck("dis_raw_m", OFS_RAW_M, 32'd5);
        readCheck("dis_acc", OFS_ACC, 32'd0);

        // Reset during deadtime
        $display("[TB] reset during DEAD");
        busWrite(OFS_CTRL, 32'h7);
        busWrite(OFS_DEADTIME, 32'd10);
        c = cyc;
        expectTrig(TT_M, c + 2);
        applyStimulus('0, '0, 8'h01, 1);
        repeat (5) @(negedge clk);
        checkOutput("dead_busy", {31'd0, Busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_dead_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rst_dead_trigger", {31'd0, Trigger}, 32'd0);
        checkOutput("rst_dead_trigtype", {30'd0, TrigType}, 32'd0);
        readCheck("rst_dead_deadtime", OFS_DEADTIME, 32'd10);
        readCheck("rst_dead_raw_m", OFS_RAW_M, 32'd0);
        repeat (3) @(negedge clk);
        c = cyc;
        expectTrig(TT_E, c + 2);
        applyStimulus(8'h10, '0, '0, 1);
        repeat (15) @(negedge clk);
        checkOutput("post_rst_trigtype", {30'd0, TrigType}, {30'd0, TT_E});
        readCheck("post_rst_acc", OFS_ACC, 32'd1);
        checkOutput("post_rst_busy", {31'd0, Busy}, 32'd0);

        checkOutput("scoreboard_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
